frame_task_scheduler: RTL and testbench
=======================================

Name: frame_task_scheduler

Overview:
- Generates the 10 Hz avionics frame from CLK_1MHZ_IN and, once per frame, runs up to 4 sensor/telemetry tasks in sequence.
- Issues each task a one-cycle START, waits for its DONE, and applies a per-slot timeout.
- Sits between the 1 MHz clock domain and the sensor interface blocks, which share the frame period.
- Reports frame count, busy, per-slot timeouts and frame overrun.

Parameters:
- FRAME_CYCLES, 100000, clock cycles per frame (10 Hz at 1 MHz); legal range 8..2^CNT_W.
- TIMEOUT_CYCLES, 20000, WAIT cycles allowed per slot before timeout; legal range 1..2^CNT_W-1.
- CNT_W, 17, width of the frame and timeout counters.
- NUM_SLOTS, 4, number of task slots (fixed at 4 for this revision).

Ports:
- CLK_1MHZ_IN  in  1  system clock, 1 MHz.
- RESET  in  1  synchronous, active-low reset.
- ENABLE  in  1  allows new sequences to start on a frame tick.
- SLOT_MASK  in  4  bit i=1 runs slot i; latched at sequence start.
- DONE  in  4  per-slot completion; only DONE[current slot] is sampled, and only in WAIT.
- OVERRUN_CLR  in  1  clears the OVERRUN flag.
- START  out  4  one-cycle start pulse to slot i.
- FRAME_TICK  out  1  one-cycle pulse at each frame boundary.
- BUSY  out  1  high while state is not IDLE.
- TIMEOUT_FLAG  out  4  sticky, per slot.
- OVERRUN  out  1  sticky; a frame tick arrived while BUSY.
- FRAME_COUNT  out  16  frame ticks since reset; wraps.

Behaviour:
- Reset (RESET=0 at a clock edge):
  - Frame counter goes to 0; state goes to IDLE.
  - START=0, FRAME_TICK=0, BUSY=0, TIMEOUT_FLAG=0, OVERRUN=0, FRAME_COUNT=0.
  - Reset overrides everything, including mid-sequence; any pending START is dropped.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps.
  - FRAME_TICK is registered: high for the one cycle after the counter holds FRAME_CYCLES-1.
  - The first tick is therefore the FRAME_CYCLES-th cycle after reset release.
  - FRAME_COUNT increments on every tick, whether or not a sequence starts. It wraps 0xFFFF->0.
- State machine (IDLE, SCAN, ISSUE, WAIT):
  - IDLE: if FRAME_TICK=1 and ENABLE=1, latch SLOT_MASK, set idx=0, go to SCAN. Otherwise stay.
  - SCAN: pick the lowest masked slot j>=idx and go to ISSUE with cur=j. If none is left, go to IDLE. An all-zero mask gives IDLE one cycle after SCAN.
  - ISSUE: START[cur]=1 for exactly this cycle, clear the timeout counter, go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - If DONE[cur]=1: clear TIMEOUT_FLAG[cur], set idx=cur+1, go to SCAN.
    - Else if the counter reaches TIMEOUT_CYCLES-1: set TIMEOUT_FLAG[cur], set idx=cur+1, go to SCAN.
    - If DONE arrives in the same cycle as the timeout, DONE wins.
- Latency:
  - FRAME_TICK in cycle n -> SCAN in n+1 -> START in n+2.
  - DONE in cycle m -> next START in m+2.
  - Timeout: START in cycle s, no DONE -> TIMEOUT_FLAG set in s+TIMEOUT_CYCLES+1, next START in s+TIMEOUT_CYCLES+2.
- DONE handling: DONE during IDLE, SCAN or ISSUE, and DONE on non-current bits, is ignored.
- Input changes mid-sequence:
  - SLOT_MASK changes have no effect; the latched copy is used.
  - ENABLE deassert does not abort; the current sequence finishes and no new one starts.
- Overrun:
  - A FRAME_TICK while BUSY=1 sets OVERRUN. The running sequence continues and that frame's sequence is skipped.
  - If OVERRUN_CLR is asserted in the same cycle as an overrun event, the set wins.
- Simultaneous events: a tick arriving in the same cycle the FSM returns to IDLE (the SCAN->IDLE edge) counts as BUSY: OVERRUN is set and no sequence starts.

Test Plan:
- Reset, frame timing, mask of 4'b0101 (FRAME_CYCLES=100, ENABLE=1): FRAME_TICK at cycles 100, 200, 300; FRAME_COUNT=3 after the third tick. START[0] 2 cycles after each tick. After DONE[0], START[2] 2 cycles later. START[1] and START[3] never pulse.
- Timeout (TIMEOUT_CYCLES=10, mask 4'b0011, DONE held 0): START[0] at s; TIMEOUT_FLAG=4'b0001 at s+11; START[1] at s+12; TIMEOUT_FLAG=4'b0011 at s+23; BUSY drops.
- Overrun: slot 0 never answers, TIMEOUT_CYCLES > FRAME_CYCLES: OVERRUN=1 at the next tick and no new START[0]. OVERRUN_CLR pulse -> OVERRUN=0. FRAME_COUNT still increments.
- Edge cases: DONE[0] pulsed in the ISSUE cycle is ignored (slot stays in WAIT). DONE and the timeout in the same cycle clear the flag. A second run of a timed-out slot with DONE clears its TIMEOUT_FLAG bit.
- Mid-sequence changes: ENABLE dropped mid-sequence -> sequence completes, no START on the next tick. RESET pulsed mid-WAIT -> all outputs zero the next cycle, first tick FRAME_CYCLES cycles after release.

Source files
------------

// File: rtl/frame_task_scheduler.sv
// Frame scheduler: derives the 10 Hz frame tick from the 1 MHz clock and, once per frame,
// sequences up to four tasks through START/DONE handshakes with a per-slot timeout.
module frame_task_scheduler #(
  parameter int unsigned FRAME_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned NUM_SLOTS      = 4
) (
  input  logic                 CLK_1MHZ_IN,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [NUM_SLOTS-1:0] SLOT_MASK,
  input  logic [NUM_SLOTS-1:0] DONE,
  input  logic                 OVERRUN_CLR,
  output logic [NUM_SLOTS-1:0] START,
  output logic                 FRAME_TICK,
  output logic                 BUSY,
  output logic [NUM_SLOTS-1:0] TIMEOUT_FLAG,
  output logic                 OVERRUN,
  output logic [15:0]          FRAME_COUNT
);

  localparam int unsigned IDX_W  = $clog2(NUM_SLOTS + 1);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     frame_cnt;
  logic [CNT_W-1:0]     tmo_cnt, tmo_cnt_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [NUM_SLOTS-1:0] flags_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [SLOT_W-1:0]    cur, cur_d;
  logic [SLOT_W-1:0]    pick;
  logic [IDX_W-1:0]     cur_next;
  logic                 found;
  logic                 frame_end;

  assign frame_end = (frame_cnt == FRAME_LAST);
  assign BUSY      = (state != ST_IDLE);
  assign cur_next  = IDX_W'(cur) + IDX_W'(1);

  always_ff @(posedge CLK_1MHZ_IN) begin
    if (!RESET) begin
      frame_cnt   <= '0;
      FRAME_TICK  <= 1'b0;
      FRAME_COUNT <= '0;
      OVERRUN     <= 1'b0;
    end else begin
      frame_cnt  <= frame_end ? '0 : frame_cnt + CNT_W'(1);
      FRAME_TICK <= frame_end;
      if (frame_end) begin
        FRAME_COUNT <= FRAME_COUNT + 16'd1;
      end
      // A tick that lands while busy must win over a simultaneous clear.
      if (FRAME_TICK && BUSY) begin
        OVERRUN <= 1'b1;
      end else if (OVERRUN_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_1MHZ_IN) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      idx          <= '0;
      cur          <= '0;
      tmo_cnt      <= '0;
      TIMEOUT_FLAG <= '0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      idx          <= idx_d;
      cur          <= cur_d;
      tmo_cnt      <= tmo_cnt_d;
      TIMEOUT_FLAG <= flags_d;
    end
  end

  always_comb begin
    state_d   = state;
    mask_d    = mask_q;
    idx_d     = idx;
    cur_d     = cur;
    tmo_cnt_d = tmo_cnt;
    flags_d   = TIMEOUT_FLAG;
    START     = '0;
    found     = 1'b0;
    pick      = '0;

    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && mask_q[SLOT_W'(i)] && (IDX_W'(i) >= idx)) begin
        found = 1'b1;
        pick  = SLOT_W'(i);
      end
    end

    case (state)
      ST_IDLE: begin
        if (FRAME_TICK && ENABLE) begin
          mask_d  = SLOT_MASK;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (found) begin
          cur_d   = pick;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        START     = NUM_SLOTS'(1) << cur;
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt + CNT_W'(1);
        // DONE is checked first so a reply on the last allowed cycle still counts.
        if (DONE[cur]) begin
          flags_d[cur] = 1'b0;
          idx_d        = cur_next;
          state_d      = ST_SCAN;
        end else if (tmo_cnt == TMO_LAST) begin
          flags_d[cur] = 1'b1;
          idx_d        = cur_next;
          state_d      = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_task_scheduler.sv
// Randomized bench for frame_task_scheduler: an interval-level model predicts START pulses
// and per-cycle status; a separate monitor pops and compares them.
module tb_frame_task_scheduler;

  localparam int F = 60;
  localparam int T = 25;

  logic       clk = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic [3:0] SLOT_MASK;
  logic [3:0] DONE;
  logic       OVERRUN_CLR;
  logic [3:0] START;
  logic       FRAME_TICK;
  logic       BUSY;
  logic [3:0] TIMEOUT_FLAG;
  logic       OVERRUN;
  logic [15:0] FRAME_COUNT;

  always #5 clk = ~clk;

  frame_task_scheduler #(
    .FRAME_CYCLES(F),
    .TIMEOUT_CYCLES(T),
    .CNT_W(17),
    .NUM_SLOTS(4)
  ) dut (
    .CLK_1MHZ_IN(clk),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .SLOT_MASK(SLOT_MASK),
    .DONE(DONE),
    .OVERRUN_CLR(OVERRUN_CLR),
    .START(START),
    .FRAME_TICK(FRAME_TICK),
    .BUSY(BUSY),
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .OVERRUN(OVERRUN),
    .FRAME_COUNT(FRAME_COUNT)
  );

  typedef struct packed {
    logic        tick;
    logic        busy;
    logic [3:0]  flags;
    logic        ovr;
    logic [15:0] fc;
  } status_t;

  typedef struct {
    int cyc;
    int slot;
  } start_t;

  status_t status_q[$];
  start_t  start_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_go   = 1'b0;
  bit mon_stop = 1'b0;
  int mg_last  = -1;
  int gc       = -1;

  // Plan of the running sequence, keyed by cycle since the last reset release.
  bit [3:0] done_at[int];
  bit [3:0] guard[int];
  bit [3:0] fset[int];
  bit [3:0] fclr[int];
  int       busy_lo;
  int       busy_hi;
  logic       ovr_m;
  logic [3:0] flags_m;

  function automatic bit tick_at(input int c);
    return (c > 0) && ((c % F) == 0);
  endfunction

  function automatic bit busy_at(input int c);
    return (c >= busy_lo) && (c <= busy_hi);
  endfunction

  // Sequence starting on the tick in cycle n: each slot gets START two cycles after the
  // previous event, then either a reply after d cycles or a timeout after T cycles.
  task automatic plan_sequence(input int n, input logic [3:0] mask);
    int t, e, last, r;
    bit [3:0] b;
    t = n + 2;
    last = n;
    for (int j = 0; j < 4; j++) begin
      if (mask[j]) begin
        b = 4'b0001 << j;
        start_q.push_back('{cyc: gc + (t - n), slot: j});
        r = int'($urandom_range(0, 9));
        if (r < 3) begin
          e = t + T;
          fset[e + 1] = fset[e + 1] | b;
        end else begin
          e = (r == 3) ? t + T : t + int'($urandom_range(1, T - 1));
          done_at[e] = done_at[e] | b;
          fclr[e + 1] = fclr[e + 1] | b;
        end
        for (int k = t + 1; k <= e; k++) guard[k] = guard[k] | b;
        t = e + 2;
        last = e;
      end
    end
    busy_lo = n + 1;
    busy_hi = (mask == 4'b0000) ? n + 1 : last + 1;
  endtask

  task automatic run_phase(input int ncyc);
    status_t s;
    int c;
    bit tk, bz;
    RESET       = 1'b0;
    ENABLE      = 1'b0;
    DONE        = '0;
    OVERRUN_CLR = 1'b0;
    SLOT_MASK   = 4'($urandom);
    while (start_q.size() > 0 && start_q[start_q.size() - 1].cyc > gc) void'(start_q.pop_back());
    done_at.delete();
    guard.delete();
    fset.delete();
    fclr.delete();
    busy_lo = 1;
    busy_hi = 0;
    ovr_m   = 1'b0;
    flags_m = '0;
    status_q.push_back('0);
    mon_go = 1'b1;
    @(negedge clk);
    gc++;
    RESET = 1'b1;
    c = 0;
    // Run past ncyc until a slot is mid-WAIT, so the next reset lands inside a handshake.
    while (c < ncyc || (!guard.exists(c) && c < ncyc + 300)) begin
      tk = tick_at(c);
      bz = busy_at(c);
      ENABLE      = ($urandom_range(0, 9) < 8);
      SLOT_MASK   = 4'($urandom);
      OVERRUN_CLR = ($urandom_range(0, 14) == 0);
      DONE        = done_at[c] | (4'($urandom) & 4'($urandom) & ~guard[c]);
      if (tk && !bz && ENABLE) plan_sequence(c, SLOT_MASK);
      ovr_m   = (tk && bz) ? 1'b1 : (OVERRUN_CLR ? 1'b0 : ovr_m);
      flags_m = (flags_m & ~fclr[c + 1]) | fset[c + 1];
      s.tick  = tick_at(c + 1);
      s.busy  = busy_at(c + 1);
      s.flags = flags_m;
      s.ovr   = ovr_m;
      s.fc    = 16'((c + 1) / F);
      status_q.push_back(s);
      @(negedge clk);
      gc++;
      c++;
    end
  endtask

  initial begin : monitor
    status_t exp_s, act;
    start_t  st;
    logic [3:0] want;
    int mg;
    mg = 0;
    wait (mon_go);
    forever begin
      @(posedge clk);
      #1;
      if (mon_stop) break;
      act.tick  = FRAME_TICK;
      act.busy  = BUSY;
      act.flags = TIMEOUT_FLAG;
      act.ovr   = OVERRUN;
      act.fc    = FRAME_COUNT;
      n_checks++;
      if (status_q.size() == 0) begin
        n_fail++;
        $display("FAIL status cyc=%0d: nothing expected, got tick=%b busy=%b", mg, act.tick, act.busy);
      end else begin
        exp_s = status_q.pop_front();
        if (act !== exp_s) begin
          n_fail++;
          $display("FAIL status cyc=%0d: got tick=%b busy=%b flags=%b ovr=%b fc=%0d, want tick=%b busy=%b flags=%b ovr=%b fc=%0d",
                   mg, act.tick, act.busy, act.flags, act.ovr, act.fc,
                   exp_s.tick, exp_s.busy, exp_s.flags, exp_s.ovr, exp_s.fc);
        end
      end
      if (START !== 4'b0000) begin
        n_checks++;
        if (start_q.size() == 0) begin
          n_fail++;
          $display("FAIL start cyc=%0d: got START=%b, want no pulse", mg, START);
        end else begin
          st = start_q.pop_front();
          want = 4'b0001 << st.slot;
          if (st.cyc != mg || START !== want) begin
            n_fail++;
            $display("FAIL start cyc=%0d: got START=%b, want START=%b at cyc %0d", mg, START, want, st.cyc);
          end
        end
      end
      mg_last = mg;
      mg++;
    end
  end

  initial begin : driver
    RESET       = 1'b0;
    ENABLE      = 1'b0;
    SLOT_MASK   = '0;
    DONE        = '0;
    OVERRUN_CLR = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    run_phase(1500);
    run_phase(1200);
    mon_stop = 1'b1;
    @(posedge clk);
    #2;
    while (start_q.size() > 0 && start_q[0].cyc <= mg_last) begin
      n_checks++;
      n_fail++;
      $display("FAIL start cyc=%0d: got no pulse, want START slot %0d", start_q[0].cyc, start_q[0].slot);
      void'(start_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
